mul_share_ctrl: RTL and testbench

MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

---
 rtl/mul_share_pkg.sv | 13 +
 rtl/mul_shift_add_core.sv | 75 +++++++
 rtl/mul_share_ctrl.sv | 127 ++++++++++++
 tb/tb_mul_share_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared definitions for the two-requester shared shift-add multiplier:
// controller state encoding and default operand width.
package mul_share_pkg;

   localparam int MUL_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mul_shift_add_core.sv
// Sequential shift-add multiplier datapath. It works on operand magnitudes and
// applies the sign to the product as the product is registered.
module mul_shift_add_core #(
   parameter int WIDTH = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               finish_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic               signed_i,
   output logic [2*WIDTH-1:0] result_o
);

   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               neg_q, neg_d;
   logic [WIDTH:0]     sum_s;
   logic [2*WIDTH-1:0] step_acc_s;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      if (sgn && v[WIDTH-1]) begin
         magnitude = -v;
      end else begin
         magnitude = v;
      end
   endfunction

   // Next-state datapath: load, one shift-add step, product capture
   always_comb begin
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      neg_d      = neg_q;
      result_d   = result_q;
      // Upper accumulator half plus carry; the multiplier drains out of the lower half.
      sum_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      step_acc_s = {sum_s, acc_q[WIDTH-1:1]};
      if (load_i) begin
         mcand_d = magnitude(a_i, signed_i);
         acc_d   = {{WIDTH{1'b0}}, magnitude(b_i, signed_i)};
         neg_d   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (|a_i) & (|b_i);
      end else if (step_i) begin
         acc_d = step_acc_s;
         if (finish_i) begin
            result_d = neg_q ? -step_acc_s : step_acc_s;
         end else begin
            result_d = result_q;
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign result_o = result_q;

endmodule

// File: rtl/mul_share_ctrl.sv
// Two-requester round-robin front end for a shared shift-add multiplier:
// grant/handshake, FSM, step counter and done pulses.
module mul_share_ctrl
   import mul_share_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             iReq0,
   input  logic             iReq1,
   input  logic [WIDTH-1:0] iA0,
   input  logic [WIDTH-1:0] iB0,
   input  logic [WIDTH-1:0] iA1,
   input  logic [WIDTH-1:0] iB1,
   input  logic             iSigned0,
   input  logic             iSigned1,
   output logic             oReady0,
   output logic             oReady1,
   output logic             oDone0,
   output logic             oDone1,
   output logic [WIDTH-1:0] oResultLow,
   output logic [WIDTH-1:0] oResultHigh,
   output logic             oBusy
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic               ptr_q, ptr_d;
   logic               owner_q, owner_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               grant0_s, grant1_s, xfer_s, last_step_s;
   logic [WIDTH-1:0]   sel_a_s, sel_b_s;
   logic               sel_signed_s;
   logic [2*WIDTH-1:0] product_s;

   // Round-robin arbitration, only while idle
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (state_q == ST_IDLE) begin
         grant0_s = iReq0 & (~iReq1 | ~ptr_q);
         grant1_s = iReq1 & (~iReq0 | ptr_q);
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   assign xfer_s       = grant0_s | grant1_s;
   assign last_step_s  = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH - 1));
   assign sel_a_s      = grant1_s ? iA1 : iA0;
   assign sel_b_s      = grant1_s ? iB1 : iB0;
   assign sel_signed_s = grant1_s ? iSigned1 : iSigned0;

   // FSM next state, step counter, owner and pointer updates
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer_s) begin
               state_d = ST_RUN;
               owner_d = grant1_s;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_step_s) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            ptr_d   = ~owner_q;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Control registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
      .clk_i    (Clock),
      .rst_i    (Reset),
      .load_i   (xfer_s),
      .step_i   (state_q == ST_RUN),
      .finish_i (last_step_s),
      .a_i      (sel_a_s),
      .b_i      (sel_b_s),
      .signed_i (sel_signed_s),
      .result_o (product_s)
   );

   assign oReady0     = grant0_s;
   assign oReady1     = grant1_s;
   assign oDone0      = (state_q == ST_DONE) & ~owner_q;
   assign oDone1      = (state_q == ST_DONE) & owner_q;
   assign oBusy       = (state_q != ST_IDLE);
   assign oResultLow  = product_s[WIDTH-1:0];
   assign oResultHigh = product_s[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Randomized and directed bench for mul_share_ctrl, checked against a
// timeline/arithmetic reference model.
module tb_mul_share_ctrl;

   localparam int W = 16;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          iReq0, iReq1, iSigned0, iSigned1;
   logic [W-1:0]  iA0, iB0, iA1, iB1;
   logic          oReady0, oReady1, oDone0, oDone1, oBusy;
   logic [W-1:0]  oResultLow, oResultHigh;

   int            checks   = 0;
   int            failures = 0;

   // Reference model: one multiply occupies the unit from its transfer cycle
   // until free_at; its product appears at done_at.
   int            cyc;
   int            xfer_at, done_at, free_at, own, ptr_m;
   logic [31:0]   exp_res, pend;
   int            grants[$];
   int            xfer_cycles[$];

   mul_share_ctrl #(.WIDTH(W)) dut (
      .Clock(Clock), .Reset(Reset),
      .iReq0(iReq0), .iReq1(iReq1),
      .iA0(iA0), .iB0(iB0), .iA1(iA1), .iB1(iB1),
      .iSigned0(iSigned0), .iSigned1(iSigned1),
      .oReady0(oReady0), .oReady1(oReady1),
      .oDone0(oDone0), .oDone1(oDone1),
      .oResultLow(oResultLow), .oResultHigh(oResultHigh),
      .oBusy(oBusy)
   );

   always #5 Clock = ~Clock;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sgn);
      longint pa, pb, p;
      if (sgn) begin
         pa = longint'($signed(a));
         pb = longint'($signed(b));
      end else begin
         pa = longint'({48'd0, a});
         pb = longint'({48'd0, b});
      end
      p = pa * pb;
      return p[31:0];
   endfunction

   task automatic check_state();
      if (cyc == done_at) begin
         exp_res = pend;
         ptr_m   = 1 - own;
      end
      check_val("busy",   64'(oBusy),  64'((cyc > xfer_at) && (cyc < free_at)));
      check_val("done0",  64'(oDone0), 64'((cyc == done_at) && (own == 0)));
      check_val("done1",  64'(oDone1), 64'((cyc == done_at) && (own == 1)));
      check_val("result", 64'({oResultHigh, oResultLow}), 64'(exp_res));
   endtask

   task automatic do_cycle(input logic r0, input logic r1,
                           input logic [W-1:0] a0, input logic [W-1:0] b0, input logic s0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1, input logic s1);
      logic er0, er1, idle;
      @(negedge Clock);
      cyc++;
      check_state();
      iReq0 = r0; iReq1 = r1;
      iA0 = a0; iB0 = b0; iSigned0 = s0;
      iA1 = a1; iB1 = b1; iSigned1 = s1;
      #1;
      idle = (cyc >= free_at);
      er0  = idle && r0 && (!r1 || ptr_m == 0);
      er1  = idle && r1 && (!r0 || ptr_m == 1);
      check_val("ready0", 64'(oReady0), 64'(er0));
      check_val("ready1", 64'(oReady1), 64'(er1));
      if (oReady0 && r0) begin grants.push_back(0); xfer_cycles.push_back(cyc); end
      if (oReady1 && r1) begin grants.push_back(1); xfer_cycles.push_back(cyc); end
      if (er0 || er1) begin
         own     = er1 ? 1 : 0;
         xfer_at = cyc;
         done_at = cyc + W + 1;
         free_at = cyc + W + 2;
         pend    = er1 ? ref_prod(a1, b1, s1) : ref_prod(a0, b0, s0);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         do_cycle(1'b0, 1'b0, W'($urandom), W'($urandom), 1'($urandom),
                  W'($urandom), W'($urandom), 1'($urandom));
      end
   endtask

   task automatic pulse_reset();
      @(negedge Clock);
      cyc++;
      check_state();
      iReq0 = 1'b0; iReq1 = 1'b0;
      #2 Reset = 1'b1;
      #1;
      check_val("rst_busy",   64'(oBusy),  64'd0);
      check_val("rst_done",   64'({oDone1, oDone0}), 64'd0);
      check_val("rst_result", 64'({oResultHigh, oResultLow}), 64'd0);
      Reset   = 1'b0;
      xfer_at = -100;
      done_at = -1;
      free_at = cyc;
      ptr_m   = 0;
      exp_res = 32'd0;
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'h8000;
         2:       return 16'hFFFF;
         3:       return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      Reset = 1'b1;
      iReq0 = 1'b0; iReq1 = 1'b0; iSigned0 = 1'b0; iSigned1 = 1'b0;
      iA0 = '0; iB0 = '0; iA1 = '0; iB1 = '0;
      cyc = 0; xfer_at = -100; done_at = -1; free_at = 0; own = 0; ptr_m = 0;
      exp_res = 32'd0; pend = 32'd0;
      repeat (2) @(negedge Clock);
      check_val("reset_busy",   64'(oBusy), 64'd0);
      check_val("reset_done",   64'({oDone1, oDone0}), 64'd0);
      check_val("reset_result", 64'({oResultHigh, oResultLow}), 64'd0);
      Reset = 1'b0;

      // Unsigned 300*200 at cycle 1, done expected at cycle 18
      do_cycle(1'b1, 1'b0, 16'd300, 16'd200, 1'b0, 16'd0, 16'd0, 1'b0);
      idle_cycles(17);
      check_val("s027_value", 64'({oResultHigh, oResultLow}), 64'h0000EA60);
      check_val("s027_cycle", 64'(cyc), 64'd18);
      idle_cycles(1);

      // Signed -7*9 on requester 1
      do_cycle(1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 16'hFFF9, 16'd9, 1'b1);
      idle_cycles(18);
      check_val("s028_value", 64'({oResultHigh, oResultLow}), 64'hFFFFFFC1);

      // Boundary products
      do_cycle(1'b1, 1'b0, 16'h8000, 16'h8000, 1'b1, 16'd0, 16'd0, 1'b0);
      idle_cycles(18);
      check_val("s030_signed", 64'({oResultHigh, oResultLow}), 64'h40000000);
      do_cycle(1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
      idle_cycles(18);
      check_val("s030_unsigned", 64'({oResultHigh, oResultLow}), 64'hFFFE0001);
      do_cycle(1'b1, 1'b0, 16'h0000, 16'h8001, 1'b1, 16'd0, 16'd0, 1'b0);
      idle_cycles(18);
      check_val("zero_operand", 64'({oResultHigh, oResultLow}), 64'h00000000);

      // Both requesters held high from reset release
      pulse_reset();
      grants.delete();
      xfer_cycles.delete();
      for (int i = 0; i < 4 * (W + 2); i++) begin
         do_cycle(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom),
                  W'($urandom), W'($urandom), 1'($urandom));
      end
      check_val("s029_count", 64'(grants.size()), 64'd4);
      for (int i = 0; i < grants.size(); i++) begin
         check_val("s029_grant", 64'(grants[i]), 64'(i % 2));
         if (i > 0) begin
            check_val("s029_spacing", 64'(xfer_cycles[i] - xfer_cycles[i-1] >= W + 2), 64'd1);
         end
      end
      idle_cycles(W + 2);

      // Reset at the 5th RUN cycle while the pointer favours requester 1
      do_cycle(1'b1, 1'b0, 16'd1234, 16'd77, 1'b0, 16'd0, 16'd0, 1'b0);
      idle_cycles(W + 1);
      do_cycle(1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 16'd999, 16'd55, 1'b0);
      idle_cycles(4);
      pulse_reset();
      idle_cycles(W + 2);
      check_val("s031_no_done", 64'({oResultHigh, oResultLow}), 64'd0);
      grants.delete();
      do_cycle(1'b1, 1'b1, 16'd11, 16'd13, 1'b0, 16'd17, 16'd19, 1'b0);
      check_val("s031_prio", 64'(grants.size() == 1 && grants[0] == 0), 64'd1);
      idle_cycles(W + 1);

      // Requester 1 pulses during requester 0's RUN
      do_cycle(1'b1, 1'b0, 16'd4321, 16'd3, 1'b0, 16'd0, 16'd0, 1'b0);
      for (int i = 0; i < W + 1; i++) begin
         do_cycle(1'b0, (i >= 3 && i < 7), W'($urandom), W'($urandom), 1'($urandom),
                  W'($urandom), W'($urandom), 1'($urandom));
      end
      check_val("s032_value", 64'({oResultHigh, oResultLow}), 64'(32'd12963));

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         do_cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                  pick_operand(), pick_operand(), 1'($urandom),
                  pick_operand(), pick_operand(), 1'($urandom));
      end
      idle_cycles(W + 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
